// File: rtl/prbs5_checker.sv
// PRBS5 (x^5+x^3+1) serial checker: self-synchronises, locks after a run of
// correct predictions, flywheels while locked and counts bit errors.
module prbs5_checker #(
  parameter int LOCK_MATCHES = 8,
  parameter int WINDOW       = 32,
  parameter int LOSS_THRESH  = 4,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_t;

  localparam logic [7:0]       MATCH_L = 8'(LOCK_MATCHES);
  localparam logic [15:0]      WIN_L   = 16'(WINDOW);
  localparam logic [15:0]      LOSS_L  = 16'(LOSS_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [4:0]       hist_q, hist_d;
  logic [2:0]       fill_q, fill_d;
  logic [7:0]       match_q, match_d;
  logic [15:0]      win_cnt_q, win_cnt_d, win_err_q, win_err_d;
  logic [CNT_W-1:0] err_cnt_d, bit_cnt_d;
  logic             pulse_d;
  logic             pred, mism;

  // hist[0] is the newest bit: b[n] = b[n-3] ^ b[n-5]
  assign pred = hist_q[2] ^ hist_q[4];
  assign mism = in_bit != pred;

  always_comb begin
    state_d   = state_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match_d   = match_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    pulse_d   = 1'b0;
    err_cnt_d = clear_cnt ? '0 : err_count;
    bit_cnt_d = clear_cnt ? '0 : bit_count;
    if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          hist_d = {hist_q[3:0], in_bit};
          fill_d = fill_q + 3'd1;
          if (fill_q == 3'd4) begin
            state_d = VERIFY;
            match_d = '0;
          end
        end
        VERIFY: begin
          // an all-zero history predicts zeros forever; never trust it
          hist_d  = {hist_q[3:0], in_bit};
          match_d = (hist_q != '0 && !mism) ? match_q + 8'd1 : '0;
          if (match_d == MATCH_L) begin
            state_d   = LOCK;
            win_cnt_d = '0;
            win_err_d = '0;
          end
        end
        LOCK: begin
          // flywheel on the prediction so bit errors cannot knock phase
          hist_d    = {hist_q[3:0], pred};
          win_cnt_d = win_cnt_q + 16'd1;
          if (bit_cnt_d != CNT_MAX) bit_cnt_d = bit_cnt_d + 1'b1;
          if (mism) begin
            pulse_d   = 1'b1;
            win_err_d = win_err_q + 16'd1;
            if (err_cnt_d != CNT_MAX) err_cnt_d = err_cnt_d + 1'b1;
          end
          if (win_err_d == LOSS_L) begin
            state_d   = HUNT;
            hist_d    = '0;
            fill_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
          end else if (win_cnt_d == WIN_L) begin
            win_cnt_d = '0;
            win_err_d = '0;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= HUNT;
      hist_q    <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      locked    <= state_d == LOCK;
      err_pulse <= pulse_d;
      err_count <= err_cnt_d;
      bit_count <= bit_cnt_d;
    end
  end

endmodule

// File: tb/tb_prbs5_checker.sv
// Scoreboard bench for prbs5_checker: a sequence-level model predicts every
// cycle's outputs; a negedge monitor pops and compares them.
module tb_prbs5_checker;

  logic       clk, reset_n, in_valid, in_bit, clear_cnt;
  logic       locked, err_pulse, locked4, err_pulse4;
  logic [15:0] err_count, bit_count;
  logic [3:0]  err_count4, bit_count4;

  prbs5_checker dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked), .err_pulse(err_pulse),
    .err_count(err_count), .bit_count(bit_count)
  );

  prbs5_checker #(.CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .clear_cnt(clear_cnt), .locked(locked4), .err_pulse(err_pulse4),
    .err_count(err_count4), .bit_count(bit_count4)
  );

  typedef struct {
    bit lk, ep;
    int ec, bc, ec4, bc4;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, errors = 0;

  // reference model: mode 0 hunt, 1 verify, 2 locked; history as a bit list
  int   m_mode, m_mc, m_wb, m_we, m_ec, m_bc, m_ec4, m_bc4;
  bit   m_h[$];
  // stream generator
  bit   gh[$];
  int   gcnt;
  logic [4:0] seed = 5'b00001;

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin
    #400000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("locked",     locked,     mon_e.lk);
      chk("err_pulse",  err_pulse,  mon_e.ep);
      chk("err_count",  err_count,  mon_e.ec);
      chk("bit_count",  bit_count,  mon_e.bc);
      chk("locked4",    locked4,    mon_e.lk);
      chk("err_count4", err_count4, mon_e.ec4);
      chk("bit_count4", bit_count4, mon_e.bc4);
    end
  end

  function automatic bit gen_next();
    bit b;
    if (gcnt < 5) b = seed[4-gcnt];
    else          b = gh[$-2] ^ gh[$-4];
    gh.push_back(b);
    if (gh.size() > 5) void'(gh.pop_front());
    gcnt++;
    return b;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_mc = 0; m_wb = 0; m_we = 0;
    m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0;
    m_h.delete();
  endfunction

  function automatic void model(bit v, bit b, bit clr);
    bit p, nz, ep;
    ep = 0;
    if (clr) begin m_ec = 0; m_bc = 0; m_ec4 = 0; m_bc4 = 0; end
    if (v) begin
      if (m_mode == 0) begin
        m_h.push_back(b);
        if (m_h.size() == 5) begin m_mode = 1; m_mc = 0; end
      end else if (m_mode == 1) begin
        p = m_h[$-2] ^ m_h[$-4];
        nz = 0;
        foreach (m_h[i]) nz |= m_h[i];
        m_mc = (nz && b == p) ? m_mc + 1 : 0;
        m_h.push_back(b);
        void'(m_h.pop_front());
        if (m_mc == 8) begin m_mode = 2; m_wb = 0; m_we = 0; end
      end else begin
        p = m_h[$-2] ^ m_h[$-4];
        m_h.push_back(p);
        void'(m_h.pop_front());
        m_wb++;
        if (m_bc < 65535) m_bc++;
        if (m_bc4 < 15) m_bc4++;
        if (b != p) begin
          ep = 1;
          m_we++;
          if (m_ec < 65535) m_ec++;
          if (m_ec4 < 15) m_ec4++;
        end
        if (m_we == 4) begin
          m_mode = 0; m_h.delete(); m_wb = 0; m_we = 0;
        end else if (m_wb == 32) begin
          m_wb = 0; m_we = 0;
        end
      end
    end
    sb.push_back('{m_mode == 2, ep, m_ec, m_bc, m_ec4, m_bc4});
  endfunction

  task automatic drive(input bit v, input bit b, input bit clr);
    @(negedge clk); #1;
    in_valid = v; in_bit = v ? b : 1'b0; clear_cnt = clr;
    model(v, v ? b : 1'b0, clr);
  endtask

  task automatic clean(input bit v, input bit flip, input bit clr);
    bit b;
    b = 0;
    if (v) b = gen_next() ^ flip;
    drive(v, b, clr);
  endtask

  // let the last driven bit land, go idle, wait for the scoreboard to empty
  task automatic drain();
    int g;
    g = 0;
    @(posedge clk); #1;
    in_valid = 0; clear_cnt = 0;
    while (sb.size() != 0 && g < 10) begin @(negedge clk); #1; g++; end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic do_reset();
    drain();
    #2 reset_n = 0;
    #1;
    chk("arst_locked", locked, 0);
    chk("arst_pulse",  err_pulse, 0);
    chk("arst_err",    err_count, 0);
    chk("arst_bits",   bit_count, 0);
    chk("arst_err4",   err_count4, 0);
    model_reset();
    @(negedge clk); #1 reset_n = 1;
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_bit = 0; clear_cnt = 0;
    gcnt = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_locked", locked, 0);
    chk("rst_pulse",  err_pulse, 0);
    chk("rst_err",    err_count, 0);
    chk("rst_bits",   bit_count, 0);
    #1 reset_n = 1;

    // clean stream from seed: lock on bit 13, 87 locked bits out of 100
    repeat (100) clean(1, 0, 0);
    drain();
    chk("t1_locked", locked, 1);
    chk("t1_err", err_count, 0);
    chk("t1_bits", bit_count, 87);

    // single error: counted, lock held, flywheel keeps phase
    repeat (5) clean(1, 0, 0);
    clean(1, 1, 0);
    repeat (10) clean(1, 0, 0);
    drain();
    chk("t2_err", err_count, 1);
    chk("t2_locked", locked, 1);

    // four errors in one window: lose lock, then relock on 13 clean bits
    for (int i = 0; i < 40 && m_wb != 0; i++) clean(1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      clean(1, 1, 0);
      if (i < 3) clean(1, 0, 0);
    end
    drain();
    chk("t3_lost", locked, 0);
    repeat (12) clean(1, 0, 0);
    drain();
    chk("t3_not_yet", locked, 0);
    clean(1, 0, 0);
    drain();
    chk("t3_relock", locked, 1);

    // three errors in each of two consecutive windows: lock holds
    for (int i = 0; i < 40 && m_wb != 0; i++) clean(1, 0, 0);
    clean(1, 0, 1);
    for (int i = 0; i < 63; i++)
      clean(1, (m_wb == 4 || m_wb == 14 || m_wb == 24), 0);
    drain();
    chk("t4_err", err_count, 6);
    chk("t4_locked", locked, 1);

    // 20 sparse errors: narrow counters saturate
    clean(1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      repeat (39) clean(1, 0, 0);
      clean(1, 1, 0);
    end
    drain();
    chk("sat_err4", err_count4, 15);
    chk("sat_bits4", bit_count4, 15);
    chk("sat_err", err_count, 20);

    // stuck-at-zero never locks
    do_reset();
    repeat (200) drive(1, 0, 0);
    drain();
    chk("t5_zero_lock", locked, 0);

    // 50% valid on a clean stream locks after 13 valid bits
    for (int i = 0; i < 30; i++) clean(i % 2, 0, 0);
    drain();
    chk("t5_half_lock", locked, 1);

    // async reset mid-lock
    do_reset();

    // randomized traffic with sparse errors, gaps and clears
    for (int i = 0; i < 1500; i++)
      clean($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 199) == 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
